// File: rtl/memory_cycle_pkg.sv
// memory_cycle_pkg
//   Constants shared by the MEM stage and its data memory: the funct3 load and
//   store size encodings, the writeback result-select encodings, the access-size
//   type and a helper that builds byte enables.
package memory_cycle_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RS_ALU = 2'b00;
   localparam logic [1:0] RS_MEM = 2'b01;
   localparam logic [1:0] RS_PC4 = 2'b10;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } acc_size_t;

   // Byte enables for an aligned access of the given size at byte offset off.
   // Halfwords use off[1] to pick the upper or lower pair of lanes.
   function automatic logic [3:0] byte_en(input acc_size_t size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/memory_cycle_data_memory.sv
// data_memory
//   Word-organised data memory: a combinational read and a synchronous write
//   with a 4-bit byte enable. The array has no reset, so its contents survive
//   a pipeline reset.
//   Ports:
//     clk    rising-edge clock
//     we     write strobe, sampled at posedge clk
//     be     byte enables, bit n covers wdata[8n+7:8n]
//     addr   word index, shared by read and write
//     wdata  write data, already replicated onto the lanes being written
//     rdata  combinational read of the word at addr
module data_memory #(
   parameter int DMEM_WORDS = 1024,
   parameter int ADDR_W     = $clog2(DMEM_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DMEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/memory_cycle.sv
// memory_cycle
//   MEM stage of the 5-stage RISC-V pipeline. It performs LB/LH/LW/LBU/LHU and
//   SB/SH/SW against the data memory and owns the MEM/WB pipeline register
//   that feeds writeback.
//   Ports:
//     clk, rst                 rising-edge clock, asynchronous active-high reset
//     RegWriteM .. WriteDataM  control and data from the EX/MEM register
//     StallM                   hold MEM/WB and suppress the store
//     FlushM                   load a bubble into MEM/WB (StallM wins)
//     RegWriteW .. MisalignW   MEM/WB register outputs
module memory_cycle
   import memory_cycle_pkg::*;
#(
   parameter int DMEM_WORDS = 1024,
   parameter int ADDR_W     = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        MemReadM,
   input  logic [1:0]  ResultSrcM,
   input  logic [2:0]  funct3M,
   input  logic [4:0]  RdM,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] ALU_ResultM,
   input  logic [31:0] WriteDataM,
   input  logic        StallM,
   input  logic        FlushM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [4:0]  RdW,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic        MisalignW
);

   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_off;
   acc_size_t         acc_size;
   logic              f3_valid;
   logic              misalign;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;
   logic [31:0]       load_data;

   logic        reg_write_q,   reg_write_d;
   logic [1:0]  result_src_q,  result_src_d;
   logic [4:0]  rd_q,          rd_d;
   logic [31:0] pc_plus4_q,    pc_plus4_d;
   logic [31:0] alu_result_q,  alu_result_d;
   logic [31:0] read_data_q,   read_data_d;
   logic        misalign_q,    misalign_d;

   // Upper address bits are dropped, so addresses wrap modulo the memory size.
   assign word_idx = ALU_ResultM[ADDR_W+1:2];
   assign byte_off = ALU_ResultM[1:0];

   // Unknown funct3 codes are checked as word accesses for alignment and
   // are then blocked from touching memory or returning data.
   always_comb begin
      acc_size = SZ_WORD;
      f3_valid = 1'b1;
      case (funct3M)
         F3_B, F3_BU: acc_size = SZ_BYTE;
         F3_H, F3_HU: acc_size = SZ_HALF;
         F3_W:        acc_size = SZ_WORD;
         default: begin
            acc_size = SZ_WORD;
            f3_valid = 1'b0;
         end
      endcase
   end

   always_comb begin
      misalign = 1'b0;
      case (acc_size)
         SZ_HALF: misalign = byte_off[0];
         SZ_WORD: misalign = (byte_off != 2'b00);
         default: misalign = 1'b0;
      endcase
   end

   // rst gates the strobe so a store sitting in MEM while reset is asserted
   // never reaches the array, even though the array itself is not reset.
   assign mem_we = MemWriteM & ~StallM & ~FlushM & ~misalign & f3_valid & ~rst;
   assign mem_be = byte_en(acc_size, byte_off);

   // Replicate the store data onto every lane; the byte enables pick the lanes.
   always_comb begin
      mem_wdata = WriteDataM;
      case (acc_size)
         SZ_BYTE: mem_wdata = {4{WriteDataM[7:0]}};
         SZ_HALF: mem_wdata = {2{WriteDataM[15:0]}};
         default: mem_wdata = WriteDataM;
      endcase
   end

   data_memory #(
      .DMEM_WORDS (DMEM_WORDS),
      .ADDR_W     (ADDR_W)
   ) u_dmem (
      .clk   (clk),
      .we    (mem_we),
      .be    (mem_be),
      .addr  (word_idx),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   always_comb begin
      byte_lane = mem_rdata[7:0];
      case (byte_off)
         2'd0: byte_lane = mem_rdata[7:0];
         2'd1: byte_lane = mem_rdata[15:8];
         2'd2: byte_lane = mem_rdata[23:16];
         2'd3: byte_lane = mem_rdata[31:24];
         default: byte_lane = mem_rdata[7:0];
      endcase
      half_lane = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   always_comb begin
      load_data = 32'h0;
      if (MemReadM && !misalign && f3_valid) begin
         case (funct3M)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {24'h0, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_data = {16'h0, half_lane};
            F3_W:    load_data = mem_rdata;
            default: load_data = 32'h0;
         endcase
      end
   end

   // MEM/WB next state: stall holds everything, flush loads a bubble.
   always_comb begin
      reg_write_d  = reg_write_q;
      result_src_d = result_src_q;
      rd_d         = rd_q;
      pc_plus4_d   = pc_plus4_q;
      alu_result_d = alu_result_q;
      read_data_d  = read_data_q;
      misalign_d   = misalign_q;
      if (!StallM) begin
         if (FlushM) begin
            reg_write_d  = 1'b0;
            result_src_d = RS_ALU;
            rd_d         = 5'd0;
            pc_plus4_d   = 32'h0;
            alu_result_d = 32'h0;
            read_data_d  = 32'h0;
            misalign_d   = 1'b0;
         end else begin
            reg_write_d  = RegWriteM;
            result_src_d = ResultSrcM;
            rd_d         = RdM;
            pc_plus4_d   = PCPlus4M;
            alu_result_d = ALU_ResultM;
            read_data_d  = load_data;
            misalign_d   = misalign & (MemReadM | MemWriteM);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         result_src_q <= RS_ALU;
         rd_q         <= 5'd0;
         pc_plus4_q   <= 32'h0;
         alu_result_q <= 32'h0;
         read_data_q  <= 32'h0;
         misalign_q   <= 1'b0;
      end else begin
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         pc_plus4_q   <= pc_plus4_d;
         alu_result_q <= alu_result_d;
         read_data_q  <= read_data_d;
         misalign_q   <= misalign_d;
      end
   end

   assign RegWriteW   = reg_write_q;
   assign ResultSrcW  = result_src_q;
   assign RdW         = rd_q;
   assign PCPlus4W    = pc_plus4_q;
   assign ALU_ResultW = alu_result_q;
   assign ReadDataW   = read_data_q;
   assign MisalignW   = misalign_q;

endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle
//   Directed bench for memory_cycle: stores and loads of every size, sign and
//   zero extension, misalignment, stall, flush, address wrap and async reset.
module tb_memory_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteM, MemWriteM, MemReadM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  funct3M;
   logic [4:0]  RdM;
   logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
   logic        StallM, FlushM;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [4:0]  RdW;
   logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
   logic        MisalignW;

   int total = 0;
   int bad   = 0;

   memory_cycle #(.DMEM_WORDS(1024), .ADDR_W(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .RegWriteM   (RegWriteM),
      .MemWriteM   (MemWriteM),
      .MemReadM    (MemReadM),
      .ResultSrcM  (ResultSrcM),
      .funct3M     (funct3M),
      .RdM         (RdM),
      .PCPlus4M    (PCPlus4M),
      .ALU_ResultM (ALU_ResultM),
      .WriteDataM  (WriteDataM),
      .StallM      (StallM),
      .FlushM      (FlushM),
      .RegWriteW   (RegWriteW),
      .ResultSrcW  (ResultSrcW),
      .RdW         (RdW),
      .PCPlus4W    (PCPlus4W),
      .ALU_ResultW (ALU_ResultW),
      .ReadDataW   (ReadDataW),
      .MisalignW   (MisalignW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic mw, input logic mr, input logic rw, input logic [1:0] rs,
                     input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                     input logic [31:0] wd);
      MemWriteM   = mw;
      MemReadM    = mr;
      RegWriteM   = rw;
      ResultSrcM  = rs;
      funct3M     = f3;
      RdM         = rd;
      ALU_ResultM = addr;
      WriteDataM  = wd;
      PCPlus4M    = addr + 32'h1000_0004;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      op(1'b1, 1'b0, 1'b0, 2'b00, f3, 5'd0, addr, wd);
      step();
   endtask

   task automatic load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr);
      op(1'b0, 1'b1, 1'b1, 2'b01, f3, rd, addr, 32'h0);
      step();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_regwrite"}, {31'h0, RegWriteW}, 32'h0);
      chk({tag, "_resultsrc"}, {30'h0, ResultSrcW}, 32'h0);
      chk({tag, "_rd"}, {27'h0, RdW}, 32'h0);
      chk({tag, "_pc4"}, PCPlus4W, 32'h0);
      chk({tag, "_alu"}, ALU_ResultW, 32'h0);
      chk({tag, "_rdata"}, ReadDataW, 32'h0);
      chk({tag, "_mis"}, {31'h0, MisalignW}, 32'h0);
   endtask

   initial begin
      rst = 1'b0;
      StallM = 1'b0;
      FlushM = 1'b0;
      op(1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 5'd3, 32'h44, 32'h0);
      #1 rst = 1'b1;
      #2;
      chk_zero("reset0");
      @(posedge clk);
      #1 rst = 1'b0;

      // word store then load
      store(3'b010, 32'h10, 32'hDEADBEEF);
      chk("sw_mis", {31'h0, MisalignW}, 32'h0);
      chk("sw_rdata", ReadDataW, 32'h0);
      load(3'b010, 5'd5, 32'h10);
      chk("lw_data", ReadDataW, 32'hDEADBEEF);
      chk("lw_rs", {30'h0, ResultSrcW}, 32'h1);
      chk("lw_rd", {27'h0, RdW}, 32'd5);
      chk("lw_rw", {31'h0, RegWriteW}, 32'h1);
      chk("lw_alu", ALU_ResultW, 32'h10);
      chk("lw_pc4", PCPlus4W, 32'h1000_0014);

      // extensions
      load(3'b000, 5'd6, 32'h13);
      chk("lb_13", ReadDataW, 32'hFFFFFFDE);
      load(3'b100, 5'd6, 32'h13);
      chk("lbu_13", ReadDataW, 32'h000000DE);
      load(3'b001, 5'd6, 32'h12);
      chk("lh_12", ReadDataW, 32'hFFFFDEAD);
      load(3'b101, 5'd6, 32'h10);
      chk("lhu_10", ReadDataW, 32'h0000BEEF);
      load(3'b000, 5'd6, 32'h10);
      chk("lb_10", ReadDataW, 32'hFFFFFFEF);

      // byte store into lane 1, upper store data bits must be ignored
      store(3'b000, 32'h11, 32'hAAAAAA55);
      load(3'b010, 5'd6, 32'h10);
      chk("sb_lw", ReadDataW, 32'hDEAD55EF);

      // halfword store into upper lanes
      store(3'b010, 32'h30, 32'h00000000);
      store(3'b001, 32'h32, 32'h9999ABCD);
      load(3'b010, 5'd6, 32'h30);
      chk("sh_lw", ReadDataW, 32'hABCD0000);

      // misaligned store suppressed
      store(3'b010, 32'h20, 32'h0BADF00D);
      store(3'b010, 32'h21, 32'h12345678);
      chk("sw_mis_flag", {31'h0, MisalignW}, 32'h1);
      load(3'b010, 5'd6, 32'h20);
      chk("sw_mis_keep", ReadDataW, 32'h0BADF00D);
      chk("lw_al_flag", {31'h0, MisalignW}, 32'h0);

      // misaligned load
      load(3'b001, 5'd6, 32'h13);
      chk("lh_mis_data", ReadDataW, 32'h0);
      chk("lh_mis_flag", {31'h0, MisalignW}, 32'h1);

      // misaligned address on a non-memory op raises no flag
      op(1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 5'd8, 32'h23, 32'h0);
      step();
      chk("alu_nomis", {31'h0, MisalignW}, 32'h0);
      chk("alu_rdata", ReadDataW, 32'h0);

      // stall: store suppressed and W held
      store(3'b010, 32'h40, 32'hCAFEF00D);
      load(3'b010, 5'd7, 32'h10);
      op(1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd9, 32'h40, 32'h11111111);
      StallM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_rd", {27'h0, RdW}, 32'd7);
         chk("stall_rdata", ReadDataW, 32'hDEAD55EF);
      end
      StallM = 1'b0;
      load(3'b010, 5'd10, 32'h40);
      chk("stall_mem", ReadDataW, 32'hCAFEF00D);

      // stall wins over flush
      op(1'b0, 1'b1, 1'b1, 2'b01, 3'b010, 5'd11, 32'h10, 32'h0);
      StallM = 1'b1;
      FlushM = 1'b1;
      step();
      chk("stflush_rd", {27'h0, RdW}, 32'd10);
      StallM = 1'b0;

      // flush: bubble, and a flushed store does not write
      step();
      chk("flush_rw", {31'h0, RegWriteW}, 32'h0);
      chk("flush_rd", {27'h0, RdW}, 32'h0);
      chk("flush_rdata", ReadDataW, 32'h0);
      chk("flush_alu", ALU_ResultW, 32'h0);
      op(1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd12, 32'h40, 32'h99999999);
      step();
      FlushM = 1'b0;
      load(3'b010, 5'd6, 32'h40);
      chk("flush_mem", ReadDataW, 32'hCAFEF00D);

      // invalid funct3
      store(3'b011, 32'h40, 32'h55555555);
      load(3'b011, 5'd6, 32'h40);
      chk("inv_load", ReadDataW, 32'h0);
      load(3'b010, 5'd6, 32'h40);
      chk("inv_store", ReadDataW, 32'hCAFEF00D);

      // address wrap
      store(3'b010, 32'h1000, 32'hA5A5A5A5);
      load(3'b010, 5'd6, 32'h0);
      chk("wrap_lw0", ReadDataW, 32'hA5A5A5A5);
      load(3'b010, 5'd6, 32'h1010);
      chk("wrap_lw1010", ReadDataW, 32'hDEAD55EF);

      // asynchronous reset mid-cycle, store in flight is dropped
      load(3'b010, 5'd3, 32'h10);
      chk("prerst_rd", {27'h0, RdW}, 32'd3);
      op(1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd4, 32'h10, 32'h77777777);
      #3 rst = 1'b1;
      #1;
      chk_zero("rst_async");
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
      op(1'b0, 1'b1, 1'b1, 2'b01, 3'b010, 5'd6, 32'h10, 32'h0);
      #2 rst = 1'b0;
      step();
      chk("rst_mem", ReadDataW, 32'hDEAD55EF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
